// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, talks to instruction memory over a
// req/ready handshake, and fills the IF/ID register with stall hold and redirect kill.
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] if_id_instruction,
  output logic [31:0] if_id_pcPlus4,
  output logic        if_id_valid
);

  typedef enum logic [1:0] {S_FETCH, S_KILL, S_HOLD} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_q, pend_d;
  logic [31:0] hold_ins_q, hold_ins_d;
  logic [31:0] hold_p4_q, hold_p4_d;
  logic [31:0] ins_q, ins_d;
  logic [31:0] p4_q, p4_d;
  logic        vld_q, vld_d;

  logic [31:0] pc_plus4;
  logic [31:0] tgt;

  assign pc_plus4 = pc_q + 32'd4;
  assign tgt      = {redirect_target[31:2], 2'b00};

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_d     = pend_q;
    hold_ins_d = hold_ins_q;
    hold_p4_d  = hold_p4_q;
    ins_d      = ins_q;
    p4_d       = p4_q;
    vld_d      = vld_q;
    case (state_q)
      S_FETCH: begin
        if (imem_ready) begin
          if (redirect) begin
            pc_d  = tgt;
            ins_d = NOP_INSTR;
            p4_d  = 32'd0;
            vld_d = 1'b0;
          end else if (stall) begin
            hold_ins_d = imem_rdata;
            hold_p4_d  = pc_plus4;
            pc_d       = pc_plus4;
            state_d    = S_HOLD;
          end else begin
            ins_d = imem_rdata;
            p4_d  = pc_plus4;
            vld_d = 1'b1;
            pc_d  = pc_plus4;
          end
        end else if (redirect) begin
          // Address must stay stable until the outstanding request completes.
          pend_d  = tgt;
          ins_d   = NOP_INSTR;
          p4_d    = 32'd0;
          vld_d   = 1'b0;
          state_d = S_KILL;
        end else if (!stall) begin
          ins_d = NOP_INSTR;
          p4_d  = 32'd0;
          vld_d = 1'b0;
        end
      end
      S_KILL: begin
        ins_d = NOP_INSTR;
        p4_d  = 32'd0;
        vld_d = 1'b0;
        if (redirect) pend_d = tgt;
        if (imem_ready) begin
          pc_d    = redirect ? tgt : pend_q;
          state_d = S_FETCH;
        end
      end
      S_HOLD: begin
        if (redirect) begin
          pc_d    = tgt;
          ins_d   = NOP_INSTR;
          p4_d    = 32'd0;
          vld_d   = 1'b0;
          state_d = S_FETCH;
        end else if (!stall) begin
          ins_d   = hold_ins_q;
          p4_d    = hold_p4_q;
          vld_d   = 1'b1;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_FETCH;
      pc_q       <= RESET_PC;
      pend_q     <= 32'd0;
      hold_ins_q <= 32'd0;
      hold_p4_q  <= 32'd0;
      ins_q      <= NOP_INSTR;
      p4_q       <= 32'd0;
      vld_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_q     <= pend_d;
      hold_ins_q <= hold_ins_d;
      hold_p4_q  <= hold_p4_d;
      ins_q      <= ins_d;
      p4_q       <= p4_d;
      vld_q      <= vld_d;
    end
  end

  assign imem_req          = !rst && (state_q != S_HOLD);
  assign imem_addr         = pc_q;
  assign pc                = pc_q;
  assign if_id_instruction = ins_q;
  assign if_id_pcPlus4     = p4_q;
  assign if_id_valid       = vld_q;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios with literal pins, then random traffic
// compared every cycle against a behavioural fetch model.
module tb_if_stage;

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst, stall, redirect, imem_ready;
  logic [31:0] redirect_target, imem_rdata, u1_rdata;
  logic        imem_req, if_id_valid, u1_req, u1_valid;
  logic [31:0] imem_addr, pc, if_id_instruction, if_id_pcPlus4;
  logic [31:0] u1_addr, u1_pc, u1_ins, u1_p4;

  always #5 clk = ~clk;

  if_stage #(.RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
    .redirect_target(redirect_target), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .pc(pc),
    .if_id_instruction(if_id_instruction), .if_id_pcPlus4(if_id_pcPlus4),
    .if_id_valid(if_id_valid)
  );

  if_stage #(.RESET_PC(32'hFFFF_FFFC), .NOP_INSTR(NOP)) u1 (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
    .redirect_target(redirect_target), .imem_req(u1_req), .imem_addr(u1_addr),
    .imem_ready(imem_ready), .imem_rdata(u1_rdata), .pc(u1_pc),
    .if_id_instruction(u1_ins), .if_id_pcPlus4(u1_p4),
    .if_id_valid(u1_valid)
  );

  int errors = 0;
  int checks = 0;

  // Behavioural model: fetch pointer, optional kill target, one-slot hold queue.
  logic [31:0] m_pc, m_pend, e_ins, e_p4;
  bit          m_kill, e_v;
  logic [63:0] hq[$];

  function automatic logic [31:0] mem(input logic [31:0] a);
    return 32'h1000_0000 + (a >> 2);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic flush();
    e_ins = NOP; e_p4 = 32'd0; e_v = 1'b0;
  endtask

  task automatic model_step(input bit r, input bit st, input bit rd,
                            input logic [31:0] t, input bit rdy);
    logic [31:0] tm;
    logic [63:0] ent;
    tm = {t[31:2], 2'b00};
    if (r) begin
      m_pc = 32'd0; m_pend = 32'd0; m_kill = 1'b0; hq.delete(); flush();
    end else if (hq.size() != 0) begin
      if (rd) begin
        hq.delete(); m_pc = tm; flush();
      end else if (!st) begin
        ent = hq.pop_front();
        e_ins = ent[63:32]; e_p4 = ent[31:0]; e_v = 1'b1;
      end
    end else if (m_kill) begin
      flush();
      if (rd) m_pend = tm;
      if (rdy) begin m_pc = m_pend; m_kill = 1'b0; end
    end else if (rdy) begin
      if (rd) begin
        m_pc = tm; flush();
      end else if (st) begin
        hq.push_back({mem(m_pc), m_pc + 32'd4}); m_pc = m_pc + 32'd4;
      end else begin
        e_ins = mem(m_pc); e_p4 = m_pc + 32'd4; e_v = 1'b1; m_pc = m_pc + 32'd4;
      end
    end else if (rd) begin
      m_pend = tm; m_kill = 1'b1; flush();
    end else if (!st) begin
      flush();
    end
  endtask

  // One clock: drive at negedge, compare the settled outputs, then advance the model.
  task automatic cyc(input bit r, input bit st, input bit rd,
                     input logic [31:0] t, input bit rdy);
    @(negedge clk);
    rst = r; stall = st; redirect = rd; redirect_target = t; imem_ready = rdy;
    imem_rdata = rdy ? mem(imem_addr) : $urandom;
    u1_rdata   = rdy ? mem(u1_addr) : $urandom;
    #1;
    chk("req",   {31'd0, imem_req}, {31'd0, (!r && hq.size() == 0)});
    chk("addr",  imem_addr, m_pc);
    chk("pc",    pc, m_pc);
    chk("valid", {31'd0, if_id_valid}, {31'd0, e_v});
    chk("instr", if_id_instruction, e_ins);
    chk("pcp4",  if_id_pcPlus4, e_p4);
    @(posedge clk);
    model_step(r, st, rd, t, rdy);
    #1;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_target = 32'd0;
    imem_ready = 1'b0; imem_rdata = 32'd0; u1_rdata = 32'd0;
    @(posedge clk);
    model_step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
    #1;
    cyc(1, 0, 0, 32'd0, 1);
    chk("rst_valid", {31'd0, if_id_valid}, 32'd0);
    chk("rst_pcp4", if_id_pcPlus4, 32'd0);
    chk("rst_pc", pc, 32'd0);
    chk("u1_rst_pc", u1_pc, 32'hFFFF_FFFC);

    // Streaming at one instruction per cycle.
    cyc(0, 0, 0, 32'd0, 1);
    chk("seq_pcp4_0", if_id_pcPlus4, 32'd4);
    chk("seq_ins_0", if_id_instruction, 32'h1000_0000);
    chk("u1_wrap_pcp4", u1_p4, 32'h0000_0000);
    chk("u1_wrap_addr", u1_addr, 32'h0000_0000);
    chk("u1_wrap_ins", u1_ins, 32'h4FFF_FFFF);
    cyc(0, 0, 0, 32'd0, 1);
    chk("seq_pcp4_1", if_id_pcPlus4, 32'd8);
    chk("seq_pc_1", pc, 32'd8);

    // Stall with ready: pc=8 word buffered, IF/ID holds the pc=4 instruction.
    cyc(0, 1, 0, 32'd0, 1);
    chk("stall_pcp4", if_id_pcPlus4, 32'd8);
    chk("stall_req", {31'd0, imem_req}, 32'd0);
    cyc(0, 1, 0, 32'd0, 1);
    cyc(0, 1, 0, 32'd0, 1);
    chk("stall_hold_pcp4", if_id_pcPlus4, 32'd8);
    cyc(0, 0, 0, 32'd0, 0);
    chk("release_pcp4", if_id_pcPlus4, 32'd12);
    chk("release_ins", if_id_instruction, 32'h1000_0002);
    chk("release_addr", imem_addr, 32'd12);

    // Two wait states: two bubbles then the pc=12 word.
    cyc(0, 0, 0, 32'd0, 0);
    chk("bubble_valid", {31'd0, if_id_valid}, 32'd0);
    chk("bubble_ins", if_id_instruction, NOP);
    cyc(0, 0, 0, 32'd0, 0);
    cyc(0, 0, 0, 32'd0, 1);
    chk("wait_pcp4", if_id_pcPlus4, 32'd16);

    // Redirect while request outstanding: address held, late response dropped.
    cyc(0, 0, 1, 32'h40, 0);
    chk("kill_valid", {31'd0, if_id_valid}, 32'd0);
    cyc(0, 0, 0, 32'd0, 0);
    chk("kill_addr", imem_addr, 32'd16);
    cyc(0, 0, 0, 32'd0, 1);
    chk("kill_newaddr", imem_addr, 32'h40);
    chk("kill_drop", {31'd0, if_id_valid}, 32'd0);
    cyc(0, 0, 0, 32'd0, 1);
    chk("redir_pcp4", if_id_pcPlus4, 32'h44);

    // Redirect beats stall; low target bits masked.
    cyc(0, 1, 1, 32'h103, 1);
    chk("prio_pc", pc, 32'h100);
    chk("prio_valid", {31'd0, if_id_valid}, 32'd0);

    // Reset mid-wait; the ready arriving with reset is ignored.
    cyc(0, 0, 0, 32'd0, 0);
    cyc(1, 0, 0, 32'd0, 1);
    chk("midrst_pc", pc, 32'd0);
    chk("midrst_valid", {31'd0, if_id_valid}, 32'd0);

    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) == 0),
          ($urandom_range(0, 7) == 0), $urandom, $urandom_range(0, 1) == 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
